// File: rtl/axi_sram_slave.sv
// AXI responder over a 2^MEM_AW x 32 internal SRAM, one transaction outstanding at a time.
// Define AXI_SRAM_RLAT_EN to insert RLAT wait cycles between the AR handshake and the first R beat.
module axi_sram_slave #(
    parameter int MEM_AW = 10,
    parameter int RLAT   = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
`ifdef AXI_SRAM_RLAT_EN
        RWAIT,
`endif
        RD,
        WR,
        WB
    } state_t;

    state_t              state;
    logic [31:0]         mem [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0]   ptr;
    logic [MEM_AW-1:0]   next_ptr;
    logic [MEM_AW-1:0]   ar_ptr;
    logic [MEM_AW-1:0]   aw_ptr;
    logic [7:0]          beat_cnt;
    logic [7:0]          len;
    logic [3:0]          id;
    logic                err;
    logic                ar_err;
    logic                aw_err;
    logic                last_beat;
    logic                unused_bits;
`ifdef AXI_SRAM_RLAT_EN
    logic [7:0]          wait_cnt;
`endif

    assign ar_ptr    = araddr[MEM_AW+1:2];
    assign aw_ptr    = awaddr[MEM_AW+1:2];
    assign ar_err    = (arburst != 2'b01) || (arsize != 3'b010);
    assign aw_err    = (awburst != 2'b01) || (awsize != 3'b010);
    assign next_ptr  = ptr + 1'b1;
    assign last_beat = (beat_cnt == len);

    // Reads win a simultaneous request, so awready is masked by arvalid.
    assign arready = aresetn && (state == IDLE);
    assign awready = arready && !arvalid;
    assign wready  = aresetn && (state == WR);

`ifdef AXI_SRAM_RLAT_EN
    assign unused_bits = ^{wid, araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};
`else
    assign unused_bits = ^{wid, araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0], 1'(RLAT)};
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            ptr      <= '0;
            beat_cnt <= '0;
            len      <= '0;
            id       <= '0;
            err      <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rresp    <= '0;
            rdata    <= '0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= '0;
`ifdef AXI_SRAM_RLAT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arvalid) begin
                        id       <= arid;
                        ptr      <= ar_ptr;
                        len      <= arlen;
                        err      <= ar_err;
                        beat_cnt <= '0;
`ifdef AXI_SRAM_RLAT_EN
                        wait_cnt <= '0;
                        state    <= RWAIT;
`else
                        state    <= RD;
                        rvalid   <= 1'b1;
                        rid      <= arid;
                        rlast    <= (arlen == 8'd0);
                        rresp    <= ar_err ? SLVERR : OKAY;
                        rdata    <= ar_err ? '0 : mem[ar_ptr];
`endif
                    end else if (awvalid) begin
                        id       <= awid;
                        ptr      <= aw_ptr;
                        len      <= awlen;
                        err      <= aw_err;
                        beat_cnt <= '0;
                        state    <= WR;
                    end
                end
`ifdef AXI_SRAM_RLAT_EN
                RWAIT: begin
                    // RLAT of 0 still costs one wait cycle; the counter only encodes 1..256.
                    if (RLAT <= 1 || wait_cnt == 8'(RLAT - 1)) begin
                        state  <= RD;
                        rvalid <= 1'b1;
                        rid    <= id;
                        rlast  <= (len == 8'd0);
                        rresp  <= err ? SLVERR : OKAY;
                        rdata  <= err ? '0 : mem[ptr];
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
`endif
                RD: begin
                    if (rready) begin
                        if (rlast) begin
                            state  <= IDLE;
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                        end else begin
                            ptr      <= next_ptr;
                            beat_cnt <= beat_cnt + 8'd1;
                            rlast    <= ((beat_cnt + 8'd1) == len);
                            rdata    <= err ? '0 : mem[next_ptr];
                        end
                    end
                end
                WR: begin
                    if (wvalid) begin
                        if (!err) begin
                            for (int unsigned i = 0; i < 4; i++) begin
                                if (wstrb[i]) mem[ptr][8*i +: 8] <= wdata[8*i +: 8];
                            end
                        end
                        ptr      <= next_ptr;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_beat || wlast) begin
                            state  <= WB;
                            bvalid <= 1'b1;
                            bid    <= id;
                            bresp  <= (err || (wlast != last_beat)) ? SLVERR : OKAY;
                        end
                    end
                end
                WB: begin
                    if (bready) begin
                        state  <= IDLE;
                        bvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table plus reset, priority and latency sequences.
// Read beats and write responses are checked against a scoreboard fed from a byte-lane memory model.
module tb_axi_sram_slave;

    localparam int MEM_AW = 10;
    localparam int RLAT   = 3;
    localparam int DEPTH  = 1 << MEM_AW;
`ifdef AXI_SRAM_RLAT_EN
    localparam int EXP_LAT = RLAT + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        aclk, aresetn;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, rresp, awburst, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    axi_sram_slave #(.MEM_AW(MEM_AW), .RLAT(RLAT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] seed;
        logic [31:0] step;
        logic [3:0]  strb;
        int          wl;
        int          hold;
        bit          chk;
        logic [31:0] d0;
        logic [1:0]  resp;
    } vec_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    vec_t        vt[$];
    logic [31:0] model [0:DEPTH-1];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout waiting on DUT", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({arready, awready, wready, rvalid, rlast, bvalid}), 32'h0);
        check({tag, "_ids"}, 32'({rid, bid, rresp, bresp}), 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input int hold_in,
                           input bit with_aw, input bit chk_d0, input logic [31:0] d0,
                           input logic [1:0] exp_resp);
        logic [MEM_AW-1:0] p;
        bit     rerr, started, first;
        int     t, lat, hold;
        rbeat_t e;
        rerr = (burst != 2'b01) || (size != 3'b010);
        p    = addr[MEM_AW+1:2];
        hold = hold_in;
        for (int b = 0; b <= int'(len); b++) begin
            rq.push_back('{rerr ? 32'h0 : model[p], exp_resp, (b == int'(len)), id});
            p = p + 1'b1;
        end
        @(negedge aclk);
        araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
        if (with_aw) awvalid = 1'b1;
        #1;
        if (with_aw) check("prio_awready_ar", awready, 0);
        t = 0;
        while (!arready && t < 200) begin
            @(negedge aclk); #1; t++;
        end
        if (!arready) begin
            fail_timeout("ar_handshake");
            arvalid = 1'b0;
            rq.delete();
            return;
        end
        lat = 0; t = 0; started = 0; first = 1;
        forever begin
            @(negedge aclk);
            arvalid = 1'b0;
            lat++; t++;
            if (t > 2000) begin
                fail_timeout("r_beats");
                rready = 1'b0;
                rq.delete();
                return;
            end
            rready = (hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            if (with_aw) check("prio_awready_rd", awready, 0);
            if (!started && rvalid) begin
                started = 1;
                check("first_rvalid_lat", lat, EXP_LAT);
            end else if (started) begin
                check("r_no_gap", rvalid, 1);
            end
            if (started && !rready && hold > 0 && rq.size() > 0) begin
                check("hold_rdata", rdata, rq[0].data);
                check("hold_rlast_rvalid", {rlast, rvalid}, {rq[0].last, 1'b1});
                hold--;
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    check("r_extra_beat", 1, 0);
                    @(posedge aclk); #1; rready = 1'b0;
                    return;
                end
                e = rq.pop_front();
                check("rdata", rdata, e.data);
                check("rresp", rresp, e.resp);
                check("rlast", rlast, e.last);
                check("rid", rid, e.id);
                if (first && chk_d0) check("rdata_first_const", rdata, d0);
                first = 0;
                if (e.last) begin
                    @(posedge aclk); #1;
                    rready = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id, input logic [31:0] seed,
                            input logic [31:0] step, input logic [3:0] strb, input int wl,
                            input int abort, input logic [1:0] exp_resp);
        logic [MEM_AW-1:0] p;
        logic [31:0] d;
        bit    werr, done;
        int    t, b;
        bexp_t e;
        werr = (burst != 2'b01) || (size != 3'b010);
        p    = addr[MEM_AW+1:2];
        bq.push_back('{exp_resp, id});
        @(negedge aclk);
        awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
        #1;
        t = 0;
        while (!awready && t < 200) begin
            @(negedge aclk); #1; t++;
        end
        if (!awready) begin
            fail_timeout("aw_handshake");
            awvalid = 1'b0;
            void'(bq.pop_back());
            return;
        end
        b = 0; t = 0; done = 0;
        while (!done) begin
            @(negedge aclk);
            awvalid = 1'b0;
            t++;
            if (t > 3000) begin
                fail_timeout("w_beats");
                wvalid = 1'b0;
                void'(bq.pop_back());
                return;
            end
            d = seed + 32'(b) * step;
            wvalid = ($urandom_range(0, 3) != 0);
            wdata = d; wstrb = strb; wlast = (b == wl); wid = ~id;
            #1;
            if (wvalid && wready) begin
                if (!werr) begin
                    for (int i = 0; i < 4; i++) if (strb[i]) model[p][8*i +: 8] = d[8*i +: 8];
                end
                p = p + 1'b1;
                done = (b == int'(len)) || (b == wl);
                b++;
                @(posedge aclk);
                if (b == abort) begin
                    @(negedge aclk);
                    aresetn = 1'b0; wvalid = 1'b0; wlast = 1'b0;
                    @(negedge aclk); #1;
                    check_reset_outputs("midrst_a");
                    @(negedge aclk); #1;
                    check_reset_outputs("midrst_b");
                    aresetn = 1'b1;
                    #1;
                    check("post_rst_ready", 32'({arready, awready, wready, bvalid, rvalid}), 32'b11000);
                    void'(bq.pop_back());
                    return;
                end
            end
        end
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        check("w_closed", wready, 0);
        t = 0;
        forever begin
            bready = ($urandom_range(0, 1) != 0);
            #1;
            if (bvalid && bready) begin
                e = bq.pop_front();
                check("bresp", bresp, e.resp);
                check("bid", bid, e.id);
                @(posedge aclk); #1;
                bready = 1'b0;
                return;
            end
            @(negedge aclk);
            t++;
            if (t > 200) begin
                fail_timeout("b_handshake");
                bready = 1'b0;
                void'(bq.pop_front());
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk); #1;
        check_reset_outputs("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("idle_after_reset", 32'({arready, awready, wready}), 32'b110);

        for (int k = 0; k < 4; k++)
            do_write(32'(k * 1024), 8'd255, 2'b01, 3'b010, 4'(k), 32'h1000_0000 * 32'(k + 1),
                     32'h1, 4'hF, 255, -1, 2'b00);

        //            wr addr          len    burst  size    seed           step     strb   wl hold chk d0             resp
        vt.push_back('{1, 32'h10,       8'd3,  2'b01, 3'b010, 32'h11,        32'h11,  4'hF,  3, 0, 0, 32'h0,         2'b00});
        vt.push_back('{0, 32'h10,       8'd3,  2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 1, 32'h11,        2'b00});
        vt.push_back('{1, 32'h20,       8'd0,  2'b01, 3'b010, 32'hAABBCCDD,  32'h0,   4'hF,  0, 0, 0, 32'h0,         2'b00});
        vt.push_back('{1, 32'h20,       8'd0,  2'b01, 3'b010, 32'h00001100,  32'h0,   4'h2,  0, 0, 0, 32'h0,         2'b00});
        vt.push_back('{0, 32'h20,       8'd0,  2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 1, 32'hAABB11DD,  2'b00});
        vt.push_back('{0, 32'h10,       8'd1,  2'b10, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 1, 32'h0,         2'b10});
        vt.push_back('{1, 32'h40,       8'd3,  2'b01, 3'b010, 32'h0BAD0001,  32'h1,   4'hF,  0, 0, 0, 32'h0,         2'b10});
        vt.push_back('{0, 32'h40,       8'd3,  2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 1, 32'h0BAD0001,  2'b00});
        vt.push_back('{1, 32'h60,       8'd1,  2'b01, 3'b010, 32'h66660000,  32'h1,   4'hF,  9, 0, 0, 32'h0,         2'b10});
        vt.push_back('{1, 32'h80,       8'd1,  2'b01, 3'b001, 32'h88880000,  32'h1,   4'hF,  1, 0, 0, 32'h0,         2'b10});
        vt.push_back('{0, 32'h80,       8'd1,  2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 0, 32'h0,         2'b00});
        vt.push_back('{0, 32'hFFC,      8'd1,  2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 5, 0, 32'h0,         2'b00});
        vt.push_back('{1, 32'hFFC,      8'd1,  2'b01, 3'b010, 32'hCAFE0000,  32'h1,   4'h9,  1, 0, 0, 32'h0,         2'b00});
        vt.push_back('{0, 32'hFFC,      8'd1,  2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 0, 32'h0,         2'b00});
        vt.push_back('{0, 32'hABCDE010, 8'd0,  2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 1, 32'h11,        2'b00});
        vt.push_back('{0, 32'h100,      8'd0,  2'b01, 3'b000, 32'h0,         32'h0,   4'h0,  0, 0, 1, 32'h0,         2'b10});
        vt.push_back('{1, 32'h200,      8'd255,2'b01, 3'b010, 32'h7E000000,  32'h3,   4'hF,255, 0, 0, 32'h0,         2'b00});
        vt.push_back('{0, 32'h200,      8'd255,2'b01, 3'b010, 32'h0,         32'h0,   4'h0,  0, 0, 1, 32'h7E000000,  2'b00});

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr)
                do_write(vt[i].addr, vt[i].len, vt[i].burst, vt[i].size, 4'(i), vt[i].seed,
                         vt[i].step, vt[i].strb, vt[i].wl, -1, vt[i].resp);
            else
                do_read(vt[i].addr, vt[i].len, vt[i].burst, vt[i].size, 4'(i), vt[i].hold,
                        0, vt[i].chk, vt[i].d0, vt[i].resp);
        end

        // Simultaneous AR/AW: the read must finish before the write is accepted.
        awaddr = 32'h90; awlen = 8'd0; awburst = 2'b01; awsize = 3'b010; awid = 4'd7;
        do_read(32'h10, 8'd1, 2'b01, 3'b010, 4'd6, 0, 1, 1, 32'h11, 2'b00);
        check("prio_awready_idle", awready, 1);
        awvalid = 1'b0;
        do_write(32'h90, 8'd0, 2'b01, 3'b010, 4'd7, 32'h9090_9090, 32'h0, 4'hF, 0, -1, 2'b00);
        do_read(32'h90, 8'd0, 2'b01, 3'b010, 4'd8, 0, 0, 1, 32'h9090_9090, 2'b00);

        // Reset after two beats of a four-beat burst: those beats stay, the rest keep old data.
        do_write(32'h100, 8'd3, 2'b01, 3'b010, 4'd5, 32'hD00D0000, 32'h1, 4'hF, 3, 2, 2'b00);
        do_read(32'h100, 8'd3, 2'b01, 3'b010, 4'd9, 0, 0, 1, 32'hD00D0000, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
